// File: rtl/shift_pkg.sv
// shift_pkg
// Shared definitions for the shift issue block: opcode encoding, field
// widths, and the command/result records carried through the datapath.
// Opcode bit 1 selects left shifts and bit 0 selects logical behaviour,
// so the shifter controls come straight from the opcode bits.
package shift_pkg;

  localparam int DATA_W = 32;
  localparam int AMT_W  = 5;
  localparam int TAG_W  = 4;
  localparam int OP_W   = 2;

  typedef enum logic [OP_W-1:0] {
    OP_SRA = 2'b00,
    OP_SRL = 2'b01,
    OP_SLL = 2'b10,
    OP_SLA = 2'b11
  } shift_op_e;

  // One queued command, exactly as accepted from upstream.
  typedef struct packed {
    shift_op_e         op;
    logic [DATA_W-1:0] data;
    logic [AMT_W-1:0]  amt;
    logic [TAG_W-1:0]  tag;
  } shift_cmd_t;

  // One completed result waiting in the output buffer.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } shift_res_t;

  function automatic logic op_is_left(input shift_op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_log(input shift_op_e op);
    return op[0];
  endfunction

endpackage

// File: rtl/shift_cmd_fifo.sv
// shift_cmd_fifo
// Command queue between the upstream handshake and the issue stage.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_push, i_cmd  write i_cmd at the tail (ignored when full)
//   i_pop          drop the head entry at the end of the cycle (ignored when empty)
//   o_head         current head entry (meaningful only when !o_empty)
//   o_full/o_empty occupancy flags, o_count current number of entries
// DEPTH must be a power of two so the pointers wrap naturally.
module shift_cmd_fifo
  import shift_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  shift_cmd_t             i_cmd,
  input  logic                   i_pop,
  output shift_cmd_t             o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PW = $clog2(DEPTH);

  shift_cmd_t        r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW:0]       r_count;

  logic              w_do_push;
  logic              w_do_pop;

  assign o_full    = (r_count == (PW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_cmd;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/shift_issue.sv
// shift_issue
// Accepts shift commands, queues them, issues them to an external shifter
// with a fixed one-cycle latency, and returns results in acceptance order.
// Ports:
//   i_clk, i_rst                      clock, asynchronous active-high reset
//   i_in_valid/o_in_ready             command handshake
//   i_in_op/i_in_data/i_in_amt/i_in_tag  command fields
//   o_sh_x/o_sh_s/o_sh_left/o_sh_log  shifter inputs
//   i_sh_z                            shifter result (one cycle after issue)
//   o_out_valid/i_out_ready           result handshake
//   o_out_data/o_out_tag              oldest buffered result
// Handshakes: a transfer happens on a rising edge where valid && ready;
// ready never depends on same-cycle downstream activity on the input side,
// and a presented result stays stable until it transfers.
module shift_issue
  import shift_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [OP_W-1:0]   i_in_op,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic [AMT_W-1:0]  i_in_amt,
  input  logic [TAG_W-1:0]  i_in_tag,
  output logic [DATA_W-1:0] o_sh_x,
  output logic [AMT_W-1:0]  o_sh_s,
  output logic              o_sh_left,
  output logic              o_sh_log,
  input  logic [DATA_W-1:0] i_sh_z,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic [TAG_W-1:0]  o_out_tag
);

  // ---------------------------------------------------------------------
  // Command queue
  // ---------------------------------------------------------------------
  shift_cmd_t               w_in_cmd;
  shift_cmd_t               w_head;
  logic                     w_full;
  logic                     w_empty;
  logic [$clog2(DEPTH):0]   w_fifo_count;
  logic                     w_push;
  logic                     w_issue;

  assign w_in_cmd.op   = shift_op_e'(i_in_op);
  assign w_in_cmd.data = i_in_data;
  assign w_in_cmd.amt  = i_in_amt;
  assign w_in_cmd.tag  = i_in_tag;

  // Ready depends only on the queue being full, never on a same-cycle pop.
  assign o_in_ready = !w_full;
  assign w_push     = i_in_valid && o_in_ready;

  shift_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_cmd   (w_in_cmd),
    .i_pop   (w_issue),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fifo_count)
  );

  // ---------------------------------------------------------------------
  // Issue / credit
  // ---------------------------------------------------------------------
  logic                     r_inflight;
  logic [TAG_W-1:0]         r_inflight_tag;
  logic [1:0]               r_out_count;
  logic [2:0]               w_occupancy;
  logic                     w_out_pop;
  logic                     w_credit;

  logic [DATA_W-1:0]        r_sh_x;
  logic [AMT_W-1:0]         r_sh_s;
  logic                     r_sh_left;
  logic                     r_sh_log;

  // Every issued command needs a guaranteed slot in the 2-entry output
  // buffer by the time its result returns. Slots are counted as buffered
  // results plus the one result still in the shifter; a pop this cycle
  // frees one slot in time for a new issue.
  assign w_occupancy = {1'b0, r_out_count} + {2'b00, r_inflight};
  assign w_out_pop   = o_out_valid && i_out_ready;
  assign w_credit    = (w_occupancy < 3'd2) ||
                       ((w_occupancy == 3'd2) && w_out_pop);
  assign w_issue     = !w_empty && w_credit;

  // The head is presented combinationally in the issue cycle; otherwise
  // the shifter inputs hold whatever was last issued.
  assign o_sh_x    = w_issue ? w_head.data           : r_sh_x;
  assign o_sh_s    = w_issue ? w_head.amt            : r_sh_s;
  assign o_sh_left = w_issue ? op_is_left(w_head.op) : r_sh_left;
  assign o_sh_log  = w_issue ? op_is_log(w_head.op)  : r_sh_log;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sh_x         <= '0;
      r_sh_s         <= '0;
      r_sh_left      <= 1'b0;
      r_sh_log       <= 1'b0;
      r_inflight     <= 1'b0;
      r_inflight_tag <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_sh_x         <= w_head.data;
        r_sh_s         <= w_head.amt;
        r_sh_left      <= op_is_left(w_head.op);
        r_sh_log       <= op_is_log(w_head.op);
        r_inflight_tag <= w_head.tag;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output buffer (2 entries, ring order)
  // ---------------------------------------------------------------------
  shift_res_t               r_ob [2];
  logic                     r_ob_wr;
  logic                     r_ob_rd;
  logic                     w_capture;

  // The shifter result is valid exactly one cycle after issue, which is
  // the cycle r_inflight is set. Reset clears r_inflight, so a result from
  // a pre-reset issue is never captured.
  assign w_capture   = r_inflight;

  assign o_out_valid = (r_out_count != 2'd0);
  assign o_out_data  = r_ob[r_ob_rd].data;
  assign o_out_tag   = r_ob[r_ob_rd].tag;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ob[0]     <= '0;
      r_ob[1]     <= '0;
      r_ob_wr     <= 1'b0;
      r_ob_rd     <= 1'b0;
      r_out_count <= 2'd0;
    end else begin
      if (w_capture) begin
        r_ob[r_ob_wr].data <= i_sh_z;
        r_ob[r_ob_wr].tag  <= r_inflight_tag;
        r_ob_wr            <= ~r_ob_wr;
      end
      if (w_out_pop) begin
        r_ob_rd <= ~r_ob_rd;
      end
      case ({w_capture, w_out_pop})
        2'b10:   r_out_count <= r_out_count + 2'd1;
        2'b01:   r_out_count <= r_out_count - 2'd1;
        default: r_out_count <= r_out_count;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_issue.sv
module tb_shift_issue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_data;
  logic [4:0]  in_amt;
  logic [3:0]  in_tag;
  logic [31:0] sh_x;
  logic [4:0]  sh_s;
  logic        sh_left;
  logic        sh_log;
  logic [31:0] sh_z;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_tag;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [35:0] exp_q[$];
  logic [3:0]  pop_tag_q[$];
  int          pop_cyc_q[$];

  shift_issue #(.DEPTH(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_op     (in_op),
    .i_in_data   (in_data),
    .i_in_amt    (in_amt),
    .i_in_tag    (in_tag),
    .o_sh_x      (sh_x),
    .o_sh_s      (sh_s),
    .o_sh_left   (sh_left),
    .o_sh_log    (sh_log),
    .i_sh_z      (sh_z),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_tag   (out_tag)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- shifter (1-cycle latency) ----------------
  function automatic logic [31:0] shifter_fn(input logic [31:0] x, input logic [4:0] s,
                                             input logic left, input logic lg);
    if (left)    return x << s;
    else if (lg) return x >> s;
    else         return $unsigned($signed(x) >>> s);
  endfunction

  always @(posedge clk) sh_z <= shifter_fn(sh_x, sh_s, sh_left, sh_log);

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d,
                                            input logic [4:0] a);
    case (op)
      2'b00:   return $unsigned($signed(d) >>> a);
      2'b01:   return d >> a;
      default: return d << a;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready)
        exp_q.push_back({in_tag, ref_shift(in_op, in_data, in_amt)});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_result", {28'd0, out_tag}, 32'hFFFF_FFFF);
        end else begin
          logic [35:0] e;
          e = exp_q.pop_front();
          check("sb_data", out_data, e[31:0]);
          check("sb_tag", {28'd0, out_tag}, {28'd0, e[35:32]});
        end
        pop_tag_q.push_back(out_tag);
        pop_cyc_q.push_back(cyc);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_cmd(input logic [1:0] op, input logic [31:0] d,
                           input logic [4:0] a, input logic [3:0] t);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_amt   = a;
    in_tag   = t;
  endtask

  task automatic drive_idle();
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [4:0]  amt;
    logic [3:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  // Single command with out_ready high: checks issue-cycle shifter controls,
  // the 3-cycle accept-to-valid latency, the result, and SH_* hold.
  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    drive_cmd(v.op, v.data, v.amt, v.tag);
    @(negedge clk);
    check("vec_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;              // accept edge k
    drive_idle();
    @(negedge clk);                  // cycle k+1: issue
    check("vec_sh_x", sh_x, v.data);
    check("vec_sh_s", {27'd0, sh_s}, {27'd0, v.amt});
    check("vec_sh_left", {31'd0, sh_left}, {31'd0, v.op[1]});
    check("vec_sh_log", {31'd0, sh_log}, {31'd0, v.op[0]});
    @(negedge clk);                  // cycle k+2
    check("vec_valid_early", {31'd0, out_valid}, 32'd0);
    @(negedge clk);                  // cycle k+3
    check("vec_valid", {31'd0, out_valid}, 32'd1);
    check("vec_data", out_data, v.exp);
    check("vec_tag", {28'd0, out_tag}, {28'd0, v.tag});
    check("vec_sh_hold", sh_x, v.data);
  endtask

  logic [1:0]  bp_op  [10];
  logic [31:0] bp_data[10];
  logic [4:0]  bp_amt [10];

  initial begin
    int          next;
    logic        acc;
    logic [31:0] held_data;
    logic [3:0]  held_tag;

    vecs[0] = '{2'b00, 32'h8000_0000, 5'd4,  4'd3, 32'hF800_0000};
    vecs[1] = '{2'b10, 32'h0000_0001, 5'd31, 4'd1, 32'h8000_0000};
    vecs[2] = '{2'b01, 32'hFFFF_FFFF, 5'd31, 4'd2, 32'h0000_0001};
    vecs[3] = '{2'b00, 32'h7FFF_FFFF, 5'd0,  4'd4, 32'h7FFF_FFFF};
    vecs[4] = '{2'b11, 32'h1234_5678, 5'd4,  4'd5, 32'h2345_6780};
    vecs[5] = '{2'b01, 32'h8000_0000, 5'd4,  4'd6, 32'h0800_0000};
    vecs[6] = '{2'b00, 32'hF000_0000, 5'd28, 4'd7, 32'hFFFF_FFFF};
    vecs[7] = '{2'b10, 32'hDEAD_BEEF, 5'd8,  4'd8, 32'hADBE_EF00};

    for (int i = 0; i < 10; i++) begin
      bp_op[i]   = 2'($urandom_range(0, 3));
      bp_data[i] = $urandom;
      bp_amt[i]  = 5'($urandom_range(0, 31));
    end

    // ---------------- reset values ----------------
    rst = 1'b1; out_ready = 1'b1;
    in_valid = 1'b0; in_op = 2'b00; in_data = '0; in_amt = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_tag", {28'd0, out_tag}, 32'd0);
    check("rst_sh_x", sh_x, 32'd0);
    check("rst_sh_s", {27'd0, sh_s}, 32'd0);
    check("rst_sh_left", {31'd0, sh_left}, 32'd0);
    check("rst_sh_log", {31'd0, sh_log}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // ---------------- directed vectors ----------------
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // ---------------- back-to-back, tags 0..7 ----------------
    repeat (3) @(negedge clk);
    pop_tag_q.delete(); pop_cyc_q.delete();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      drive_cmd(2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)), 4'(i));
    end
    @(posedge clk); #1 drive_idle();
    repeat (15) @(negedge clk);
    check("b2b_count", pop_tag_q.size(), 32'd8);
    for (int i = 0; i < pop_tag_q.size(); i++) begin
      check("b2b_tag_order", {28'd0, pop_tag_q[i]}, i);
      if (i > 0) check("b2b_consecutive", pop_cyc_q[i], pop_cyc_q[i-1] + 1);
    end

    // ---------------- back-pressure: DEPTH+2 held ----------------
    pop_tag_q.delete(); pop_cyc_q.delete();
    @(posedge clk); #1 out_ready = 1'b0;
    next = 0;
    for (int t = 0; t < 15; t++) begin
      drive_cmd(bp_op[next], bp_data[next], bp_amt[next], 4'(next));
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) next++;
    end
    @(negedge clk);
    check("bp_accepted", next, 32'd6);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    held_data = out_data; held_tag = out_tag;
    repeat (3) @(negedge clk);
    check("bp_hold_data", out_data, held_data);
    check("bp_hold_tag", {28'd0, out_tag}, {28'd0, held_tag});
    @(posedge clk); #1 out_ready = 1'b1;
    for (int t = 0; t < 40 && next < 10; t++) begin
      drive_cmd(bp_op[next], bp_data[next], bp_amt[next], 4'(next));
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) next++;
    end
    drive_idle();
    check("bp_all_accepted", next, 32'd10);
    repeat (12) @(negedge clk);
    check("bp_count", pop_tag_q.size(), 32'd10);
    for (int i = 0; i < pop_tag_q.size(); i++)
      check("bp_tag_order", {28'd0, pop_tag_q[i]}, i);

    // ---------------- reset with an issue in flight ----------------
    @(posedge clk); #1 out_ready = 1'b0;
    drive_cmd(2'b10, 32'h0000_00F1, 5'd1, 4'd9);
    @(posedge clk); #1 drive_cmd(2'b01, 32'hA5A5_0000, 5'd3, 4'd10);
    @(posedge clk); #1 drive_cmd(2'b00, 32'h1111_1111, 5'd2, 4'd11);
    @(posedge clk); #3;
    drive_idle();
    check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_sh_x", sh_x, 32'd0);
    check("mid_rst_sh_s", {27'd0, sh_s}, 32'd0);
    check("mid_rst_sh_left", {31'd0, sh_left}, 32'd0);
    check("mid_rst_sh_log", {31'd0, sh_log}, 32'd0);
    check("mid_rst_out_data", out_data, 32'd0);
    exp_q.delete(); pop_tag_q.delete(); pop_cyc_q.delete();
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      check("post_rst_no_stale", {31'd0, out_valid}, 32'd0);
    end
    run_vec(vecs[0]);

    // ---------------- drain ----------------
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
    @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_issue.md
SHIFT_ISSUE -- requirements
Module: shift_issue

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO entries (power of 2, >=2).
REQ-002 CLOCK  in  1  single clock; all state changes on rising edge.
REQ-003 RESET  in  1  asynchronous, active-high reset.
REQ-004 IN_VALID  in  1  upstream command valid.
REQ-005 IN_READY  out  1  block can accept a command this cycle.
REQ-006 IN_OP  in  2  shift opcode: 00 SRA, 01 SRL, 10 SLL, 11 SLA.
REQ-007 IN_DATA  in  32  operand to shift.
REQ-008 IN_AMT  in  5  shift amount, 0..31.
REQ-009 IN_TAG  in  4  opaque tag returned with the result.
REQ-010 SH_X  out  32  operand to the shifter X input.
REQ-011 SH_S  out  5  amount to the shifter S input.
REQ-012 SH_LEFT  out  1  shifter LEFT control; equals opcode bit 1.
REQ-013 SH_LOG  out  1  shifter LOG control; equals opcode bit 0.
REQ-014 SH_Z  in  32  shifter result, valid the cycle after the shifter samples its inputs (fixed 1-cycle latency).
REQ-015 OUT_VALID  out  1  result valid.
REQ-016 OUT_READY  in  1  downstream accepts result.
REQ-017 OUT_DATA  out  32  shifted result.
REQ-018 OUT_TAG  out  4  tag of the command that produced OUT_DATA.

Function
REQ-019 A command is accepted on a rising edge where IN_VALID && IN_READY and is written to the FIFO tail.
REQ-020 IN_READY shall be 1 iff FIFO count < DEPTH; no same-cycle bypass when full, even if a pop occurs.
REQ-021 Issue occurs in a cycle where the FIFO is non-empty and credit exists; the FIFO head drives SH_X/SH_S/SH_LEFT/SH_LOG and is popped at the cycle end.
REQ-022 Credit exists iff (out_count + inflight) < 2, or == 2 while OUT_VALID && OUT_READY in the same cycle.
REQ-023 When not issuing, SH_* shall hold their last values; inflight clears.
REQ-024 On issue, inflight sets and the head tag is registered; the next cycle SH_Z and that tag are written into a 2-entry output buffer.
REQ-025 OUT_VALID = out_count != 0; OUT_DATA/OUT_TAG show the oldest buffer entry; it pops on OUT_VALID && OUT_READY.
REQ-026 Results shall leave strictly in acceptance order; no result is dropped or duplicated.
REQ-027 Latency: accepted at edge k -> issued in cycle k+1 -> captured end of k+2 -> OUT_VALID in cycle k+3.
REQ-028 With OUT_READY held high, sustained throughput is one result per cycle.
REQ-029 Simultaneous capture and pop in the output buffer shall keep out_count unchanged and preserve order.
REQ-030 OUT_VALID, once asserted, holds with stable OUT_DATA/OUT_TAG until popped.
REQ-031 Maximum commands held while OUT_READY is low = DEPTH + 2.

Reset
REQ-032 RESET asserted clears FIFO count/pointers, inflight, and out_count immediately, without waiting for CLOCK.
REQ-033 Reset values: IN_READY=1, OUT_VALID=0, OUT_DATA=0, OUT_TAG=0, SH_X=0, SH_S=0, SH_LEFT=0, SH_LOG=0.
REQ-034 Reset mid-operation discards all queued and in-flight commands; SH_Z from a pre-reset issue shall never reach OUT_DATA.

Structure
REQ-035 Shared package shift_pkg holds the opcode constants (SRA/SRL/SLL/SLA), data width 32, amount width 5, and tag width 4.
REQ-036 Command storage is one sub-module, shift_cmd_fifo (parameter DEPTH, payload op+data+amt+tag); credit logic and the output buffer stay in shift_issue.

Verification
REQ-037 The bench instantiates the real shifter on SH_*/SH_Z. Every case checks against a reference model (<<, >>, >>> on signed data).
REQ-038 SRA 0x80000000 amt 4 tag 3 -> OUT_VALID 3 cycles after accept, OUT_DATA=0xF8000000, OUT_TAG=3.
REQ-039 SLL 0x00000001 amt 31 -> 0x80000000; SRL 0xFFFFFFFF amt 31 -> 0x00000001; SRA 0x7FFFFFFF amt 0 -> 0x7FFFFFFF.
REQ-040 8 back-to-back random ops, tags 0..7, OUT_READY=1 -> 8 results on 8 consecutive cycles, tags 0..7 in order.
REQ-041 OUT_READY=0, 10 ops offered -> exactly 6 accepted, then IN_READY=0. Raise OUT_READY -> 6 correct results in order, then the remaining 4 are accepted.
REQ-042 Fill the FIFO, pulse RESET mid-cycle while an issue is in flight -> OUT_VALID=0, IN_READY=1, SH_*=0 immediately, and no stale result appears over the next 5 cycles.
